// File: rtl/fifo_stream_reader.sv
// Read-side FIFO controller: issues rd_en, absorbs the one-cycle read latency in a
// 2-entry skid buffer, and presents a valid/ready stream framed by m_last.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  idle
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [1:0]            occ;
  logic                  inflight;
  logic [BW-1:0]         beat;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic                  pop;
  logic [2:0]            level;

  assign pop     = m_valid && m_ready;
  assign level   = 3'(occ) + 3'(inflight) - 3'(pop);
  assign m_valid = (occ != 2'd0);
  assign m_data  = head ? buf1 : buf0;
  assign m_last  = m_valid && (beat == LAST_BEAT);
  assign idle    = (occ == 2'd0) && !inflight;

  // Gated by rst_n so no read strobe reaches the FIFO while it is held in reset.
  assign fifo_rd_en = rst_n && enable && !fifo_empty && (level < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      beat     <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ + {1'b0, inflight} - {1'b0, pop};
      if (inflight) begin
        if (tail)
          buf1 <= fifo_rdata;
        else
          buf0 <= fifo_rdata;
        tail <= ~tail;
      end
      if (pop) begin
        head <= ~head;
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
    end
  end

  // The issue rule leaves no slot for a capture while the buffer is full.
  a_no_capture_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight && pop && (occ == 2'd2)));

  a_occ_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    occ != 2'd3);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO read port and a
// second BURST_LEN=1 instance observing the same input stream.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rdata = 8'h00;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       idle;

  logic       b1_rd_en;
  logic       b1_valid;
  logic [7:0] b1_data;
  logic       b1_last;
  logic       b1_idle;

  int checks = 0;
  int errors = 0;

  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .idle(idle)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(b1_rd_en), .fifo_rdata(fifo_rdata), .m_valid(b1_valid),
    .m_ready(m_ready), .m_data(b1_data), .m_last(b1_last), .idle(b1_idle)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO read port with one-cycle registered read latency.
  logic [7:0] fifo_mem [0:511];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rdata <= fifo_mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Monitor: counts strobes and logs every accepted beat.
  int         rd_count = 0;
  int         pop_n = 0;
  logic [7:0] pop_data [0:255];
  logic       pop_last [0:255];
  int         b1_mismatch = 0;
  int         b1_valid_cycles = 0;

  always @(negedge clk) begin
    if (fifo_rd_en) rd_count <= rd_count + 1;
    if (m_valid && m_ready) begin
      pop_data[pop_n] <= m_data;
      pop_last[pop_n] <= m_last;
      pop_n           <= pop_n + 1;
    end
    if (rst_n) begin
      if (b1_last !== b1_valid) b1_mismatch <= b1_mismatch + 1;
      if (b1_valid) b1_valid_cycles <= b1_valid_cycles + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    enable  = en;
    m_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadFifo(input logic [7:0] first, input int n, input logic [7:0] step);
    logic [7:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr] = v;
      wr_ptr = wr_ptr + 1;
      v = v + step;
    end
  endtask

  task automatic holdReset();
    rst_n  = 1'b0;
    wr_ptr = rd_ptr;
  endtask

  initial begin
    logic [5:0] exp_rd;
    logic [5:0] exp_v;
    logic [5:0] exp_last;
    logic [5:0] exp_idle;
    logic [7:0] exp_d [0:5];
    int         rd_b;
    int         pop_b;
    int         cyc;
    logic       bad_occ;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    tick();
    tick();

    // Reset with a non-empty FIFO and enable high.
    loadFifo(8'h11, 4, 8'h11);
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("reset_rd_en", fifo_rd_en, 0);
    checkOutput("reset_m_valid", m_valid, 0);
    checkOutput("reset_m_last", m_last, 0);
    checkOutput("reset_m_data", m_data, 8'h00);
    checkOutput("reset_idle", idle, 1);

    // Streaming 0x11..0x44 with m_ready high.
    tick();
    rd_b  = rd_count;
    pop_b = pop_n;
    rst_n = 1'b1;
    #1;
    checkOutput("stream_first_strobe", fifo_rd_en, 1);
    exp_rd   = 6'b000111;
    exp_v    = 6'b011110;
    exp_last = 6'b010000;
    exp_idle = 6'b100000;
    exp_d[0] = 8'h00; exp_d[1] = 8'h11; exp_d[2] = 8'h22;
    exp_d[3] = 8'h33; exp_d[4] = 8'h44; exp_d[5] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("stream_rd_en_%0d", k), fifo_rd_en, exp_rd[k]);
      checkOutput($sformatf("stream_valid_%0d", k), m_valid, exp_v[k]);
      checkOutput($sformatf("stream_last_%0d", k), m_last, exp_last[k]);
      checkOutput($sformatf("stream_idle_%0d", k), idle, exp_idle[k]);
      if (exp_v[k]) checkOutput($sformatf("stream_data_%0d", k), m_data, exp_d[k]);
    end
    checkOutput("stream_strobes", rd_count - rd_b, 4);
    checkOutput("stream_pops", pop_n - pop_b, 4);

    // Backpressure: only two reads beyond the last pop.
    holdReset();
    applyStimulus(1'b1, 1'b0);
    loadFifo(8'h11, 4, 8'h11);
    tick();
    rd_b  = rd_count;
    pop_b = pop_n;
    rst_n = 1'b1;
    repeat (6) tick();
    checkOutput("bp_strobes", rd_count - rd_b, 2);
    checkOutput("bp_rd_en_low", fifo_rd_en, 0);
    checkOutput("bp_valid", m_valid, 1);
    checkOutput("bp_hold_data", m_data, 8'h11);
    checkOutput("bp_last", m_last, 0);
    applyStimulus(1'b1, 1'b1);
    repeat (8) tick();
    checkOutput("bp_pops", pop_n - pop_b, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp_data_%0d", i), pop_data[pop_b + i], 8'h11 * (i + 1));
      checkOutput($sformatf("bp_lastflag_%0d", i), pop_last[pop_b + i], (i == 3));
    end
    checkOutput("bp_idle", idle, 1);

    // Random m_ready over 64 words 0x00..0x3F.
    holdReset();
    applyStimulus(1'b1, 1'b0);
    loadFifo(8'h00, 64, 8'h01);
    tick();
    rd_b    = rd_count;
    pop_b   = pop_n;
    rst_n   = 1'b1;
    bad_occ = 1'b0;
    cyc     = 0;
    while ((pop_n - pop_b) < 64 && cyc < 600) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (((rd_count - rd_b) - (pop_n - pop_b)) > 2) bad_occ = 1'b1;
    end
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("rand_pops", pop_n - pop_b, 64);
    for (int i = 0; i < 64; i++) begin
      checkOutput($sformatf("rand_data_%0d", i), pop_data[pop_b + i], i);
      checkOutput($sformatf("rand_last_%0d", i), pop_last[pop_b + i], ((i % 4) == 3));
    end
    checkOutput("rand_occ_bound", bad_occ, 0);

    // Enable dropped after the second strobe of a 6-word FIFO.
    holdReset();
    applyStimulus(1'b1, 1'b1);
    loadFifo(8'hA0, 6, 8'h01);
    tick();
    rd_b  = rd_count;
    pop_b = pop_n;
    rst_n = 1'b1;
    tick();
    checkOutput("en_second_strobe", fifo_rd_en, 1);
    tick();
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("en_drop_rd_en", fifo_rd_en, 0);
    repeat (6) tick();
    checkOutput("en_drop_strobes", rd_count - rd_b, 2);
    checkOutput("en_drop_pops", pop_n - pop_b, 2);
    checkOutput("en_drop_data0", pop_data[pop_b], 8'hA0);
    checkOutput("en_drop_data1", pop_data[pop_b + 1], 8'hA1);
    checkOutput("en_drop_idle", idle, 1);
    applyStimulus(1'b1, 1'b1);
    repeat (10) tick();
    checkOutput("en_resume_strobes", rd_count - rd_b, 6);
    checkOutput("en_resume_pops", pop_n - pop_b, 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("en_data_%0d", i), pop_data[pop_b + i], 8'hA0 + i);
      checkOutput($sformatf("en_last_%0d", i), pop_last[pop_b + i], (i == 3));
    end

    // Reset asserted mid-frame with the skid buffer full.
    holdReset();
    applyStimulus(1'b1, 1'b1);
    loadFifo(8'h60, 8, 8'h01);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 1'b0);
    tick();
    tick();
    checkOutput("mid_full_valid", m_valid, 1);
    checkOutput("mid_full_data", m_data, 8'h61);
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("mid_pre_rd_en", fifo_rd_en, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", m_valid, 0);
    checkOutput("mid_rst_last", m_last, 0);
    checkOutput("mid_rst_rd_en", fifo_rd_en, 0);
    wr_ptr = rd_ptr;
    loadFifo(8'h50, 4, 8'h01);
    tick();
    rd_b  = rd_count;
    pop_b = pop_n;
    rst_n = 1'b1;
    repeat (10) tick();
    checkOutput("mid_after_pops", pop_n - pop_b, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("mid_after_data_%0d", i), pop_data[pop_b + i], 8'h50 + i);
      checkOutput($sformatf("mid_after_last_%0d", i), pop_last[pop_b + i], (i == 3));
    end

    // Single-beat frames: m_last tracks m_valid.
    checkOutput("b1_last_eq_valid", b1_mismatch, 0);
    checkOutput("b1_saw_valid", (b1_valid_cycles > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the team's synchronous FIFOs. It drives the FIFO's `rd_en` from `empty`, absorbs the FIFO's one-cycle registered read latency in a 2-entry output skid buffer, and presents the data as a valid/ready stream. Beats are grouped into fixed-length frames marked with `m_last`. It sits between any FIFO read port and a downstream stream consumer.

## Interface
- `DATA_WIDTH`, 8, width of `fifo_rdata` and `m_data`.
- `BURST_LEN`, 4, beats per frame; must be ≥1. `m_last` marks beat `BURST_LEN-1`.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst_n`  in  1  reset, asynchronous and active-low; async assert, deassert synchronous to `clk`.
- `enable`  in  1  permits new FIFO reads; deasserting does not drop words already read.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_rd_en`  out  1  FIFO read strobe (combinational).
- `fifo_rdata`  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  consumer accepts when high with `m_valid`.
- `m_data`  out  DATA_WIDTH  head word of the skid buffer.
- `m_last`  out  1  head word is the final beat of its frame.
- `idle`  out  1  no word buffered and no read in flight.

## Operation
- State:
  - `occ`, 0..2 words held in a 2-entry circular buffer with 1-bit head/tail pointers.
  - `inflight`, 1 bit, set when a read was issued in the previous cycle.
  - `beat`, width `$clog2(BURST_LEN)`, minimum 1 bit, counts 0..BURST_LEN-1.
- `pop = m_valid && m_ready`.
- `fifo_rd_en = enable && !fifo_empty && (occ + inflight - pop < 2)`. Evaluate the sum at 3-bit width so it cannot underflow.
- `fifo_rd_en` is never asserted while `fifo_empty` is high, so every strobe is an accepted read.
- `inflight <= fifo_rd_en` each cycle.
- When `inflight` is 1, write `fifo_rdata` into the tail entry and advance the tail pointer.
- On `pop`, advance the head pointer.
- `occ <= occ + inflight - pop`. The issue rule guarantees `occ` never exceeds 2, so no overflow check is needed.
- `m_valid = (occ != 0)`.
- `m_data` shows the head entry. It holds its value while `m_valid && !m_ready`.
- `m_last = m_valid && (beat == BURST_LEN-1)`.
- `beat` changes only on `pop`: it increments, and wraps to 0 after BURST_LEN-1.
- `BURST_LEN == 1`: `m_last = m_valid`.
- `idle = (occ == 0) && !inflight`.
- `enable` falling with words in flight or buffered: no new reads are issued, and all held words are still delivered in order.
- Simultaneous capture and pop with `occ == 2`: impossible by construction. Add an assertion that checks this.
- Simultaneous capture and pop with `occ == 1`: `occ` stays at 1, head and tail both advance, and the word order is preserved.

## Timing
- Reset values (immediate on `rst_n` low):
  - `occ = 0`, `inflight = 0`, `beat = 0`, pointers 0, buffer entries 0.
  - Hence `m_valid = 0`, `m_last = 0`, `m_data = 0`, `idle = 1`.
  - `fifo_rd_en` is 0 while `rst_n` is low, regardless of other inputs.
- Latency: `fifo_rd_en` high in cycle N → `fifo_rdata` captured at the end of N+1 → `m_valid` high in N+2. First-word latency from `fifo_empty` falling is 2 cycles.
- Throughput: 1 word/cycle sustained while `m_ready` is high and the FIFO is non-empty. This steady state is `occ = 1`, `inflight = 1`.
- Backpressure: with `m_ready` low, at most 2 words are read beyond the last pop, then `fifo_rd_en` stays low.
- Reset mid-operation: buffered and in-flight words are discarded and `beat` returns to 0. The FIFO is reset by the same `rst_n` domain; the integrator guarantees this.

## Test plan
- Reset, then FIFO preloaded with 0x11,0x22,0x33,0x44, `enable = 1`, `m_ready = 1`:
  - `fifo_rd_en` high for 4 consecutive cycles.
  - `m_data` = 0x11..0x44 on consecutive cycles starting 2 cycles after the first strobe.
  - `m_last` high only with 0x44.
  - `idle` returns to 1.
- Same data with `m_ready = 0`:
  - Exactly 2 `fifo_rd_en` pulses, then none.
  - `m_data` holds 0x11 with `m_valid = 1`.
  - After `m_ready` rises, all 4 words arrive in order with no loss or duplication.
- Random `m_ready` (50%) over 64 words 0x00..0x3F:
  - Output sequence identical to input.
  - `m_last` on every 4th beat (0x03, 0x07, …).
  - `occ` never exceeds 2.
- Drop `enable` after the second strobe of a 6-word FIFO:
  - The 2 issued words are still delivered.
  - No further `fifo_rd_en`.
  - Re-raising `enable` resumes at word 3, and `beat` continues from 2.
- Assert `rst_n` low while `occ = 2` mid-frame:
  - `m_valid`, `m_last`, and `fifo_rd_en` go 0 immediately.
  - After release, the first delivered word is beat 0.
- `BURST_LEN = 1`: `m_last` equals `m_valid` on every beat.
